// File: rtl/uart_pkg.sv
// uart_pkg: definitions shared by the UART transmitter and receiver.
//   uart_state_e   - frame state encoding (IDLE, START, DATA, PARITY, STOP)
//   PARITY_*       - parity mode selectors for the PARITY parameter
//   UART_BYTE_W    - width of the parallel data port
//   parity_bit()   - parity over the low nbits of a byte for a given mode
package uart_pkg;

    localparam int unsigned UART_BYTE_W   = 8;
    localparam int unsigned MIN_DATA_BITS = 5;
    localparam int unsigned MAX_DATA_BITS = 8;

    localparam int unsigned PARITY_NONE = 0;
    localparam int unsigned PARITY_EVEN = 1;
    localparam int unsigned PARITY_ODD  = 2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_e;

    // Even parity is the XOR of the data bits; odd parity is its inverse.
    function automatic logic parity_bit(
        input logic [UART_BYTE_W-1:0] value,
        input int unsigned            nbits,
        input int unsigned            mode
    );
        logic p;
        p = 1'b0;
        for (int unsigned b = 0; b < MAX_DATA_BITS; b++) begin
            if (b < nbits) begin
                p = p ^ value[3'(b)];
            end
        end
        return (mode == PARITY_ODD) ? ~p : p;
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period timer, counts 0..CLKS_PER_BIT-1 and wraps.
//   clock  - rising-edge clock
//   reset  - synchronous, active-high
//   clear  - holds the counter at 0 (used while the line is idle)
//   tick   - high in the cycle the counter sits at terminal count
module uart_baud_tick #(
    parameter int unsigned CLKS_PER_BIT = 16
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    output logic tick
);

    // A divider of 1 still needs a 1-bit counter.
    localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] TERMINAL = CNT_W'(CLKS_PER_BIT - 1);

    if (CLKS_PER_BIT == 0) begin : g_bad_clks
        $error("uart_baud_tick: CLKS_PER_BIT must be at least 1");
    end

    logic [CNT_W-1:0] count;

    // Counter: cleared on reset/clear, wraps at terminal count.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count <= '0;
        end else if (count == TERMINAL) begin
            count <= '0;
        end else begin
            count <= count + CNT_W'(1);
        end
    end

    assign tick = (count == TERMINAL);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: UART transmitter, sends one byte per start/ready handshake as an
// LSB-first frame: start bit, DATA_BITS data bits, optional parity, stop bit(s).
//   clock      - rising-edge clock
//   reset      - synchronous, active-high; aborts any frame in flight
//   enable     - gates acceptance of new frames only
//   start      - request to send data (accepted when ready)
//   data       - payload, bits [DATA_BITS-1:0] are sent
//   ready      - combinational: a start this cycle will be accepted
//   busy       - a frame is on the line
//   serial_out - registered line output, idles high
//   done       - one-cycle pulse in the first idle cycle after a frame
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = 0,
    parameter int unsigned STOP_BITS    = 1
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   start,
    input  logic [UART_BYTE_W-1:0] data,
    output logic                   ready,
    output logic                   busy,
    output logic                   serial_out,
    output logic                   done
);

    localparam int unsigned BIT_CNT_W = $clog2(DATA_BITS + 1);
    localparam logic [BIT_CNT_W-1:0] LAST_DATA = BIT_CNT_W'(DATA_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] LAST_STOP = BIT_CNT_W'(STOP_BITS - 1);
    localparam logic HAS_PARITY = (PARITY != PARITY_NONE);

    if (CLKS_PER_BIT == 0) begin : g_bad_clks
        $error("uart_tx: CLKS_PER_BIT must be at least 1");
    end
    if (DATA_BITS < MIN_DATA_BITS || DATA_BITS > MAX_DATA_BITS) begin : g_bad_data_bits
        $error("uart_tx: DATA_BITS must be in 5..8");
    end
    if (PARITY > PARITY_ODD) begin : g_bad_parity
        $error("uart_tx: PARITY must be 0 (none), 1 (even) or 2 (odd)");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end

    uart_state_e            state;
    logic [UART_BYTE_W-1:0] shreg;
    logic [BIT_CNT_W-1:0]   bit_cnt;
    logic                   parity_q;
    logic                   tick;
    logic                   accept_c;
    logic                   baud_clear_c;

    assign ready        = (state == ST_IDLE) && enable;
    assign accept_c     = start && ready;
    // Holding the timer at 0 while idle makes every frame start on a fresh bit period.
    assign baud_clear_c = (state == ST_IDLE);

    uart_baud_tick #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clock(clock),
        .reset(reset),
        .clear(baud_clear_c),
        .tick (tick)
    );

    // Frame FSM; serial_out is loaded one edge ahead so the line is a pure register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= ST_IDLE;
            serial_out <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            shreg      <= '0;
            bit_cnt    <= '0;
            parity_q   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept_c) begin
                        shreg      <= data;
                        parity_q   <= parity_bit(data, DATA_BITS, PARITY);
                        bit_cnt    <= '0;
                        serial_out <= 1'b0;
                        busy       <= 1'b1;
                        state      <= ST_START;
                    end
                end

                ST_START: begin
                    if (tick) begin
                        serial_out <= shreg[0];
                        shreg      <= shreg >> 1;
                        state      <= ST_DATA;
                    end
                end

                // bit_cnt indexes the data bit currently on the line.
                ST_DATA: begin
                    if (tick) begin
                        if (bit_cnt == LAST_DATA) begin
                            bit_cnt <= '0;
                            if (HAS_PARITY) begin
                                serial_out <= parity_q;
                                state      <= ST_PARITY;
                            end else begin
                                serial_out <= 1'b1;
                                state      <= ST_STOP;
                            end
                        end else begin
                            bit_cnt    <= bit_cnt + BIT_CNT_W'(1);
                            serial_out <= shreg[0];
                            shreg      <= shreg >> 1;
                        end
                    end
                end

                ST_PARITY: begin
                    if (tick) begin
                        serial_out <= 1'b1;
                        state      <= ST_STOP;
                    end
                end

                // bit_cnt is reused to count stop-bit periods.
                ST_STOP: begin
                    if (tick) begin
                        if (bit_cnt == LAST_STOP) begin
                            bit_cnt <= '0;
                            busy    <= 1'b0;
                            done    <= 1'b1;
                            state   <= ST_IDLE;
                        end else begin
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                        end
                    end
                end

                default: begin
                    serial_out <= 1'b1;
                    busy       <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: five transmitter configurations driven together. A queue model
// predicts every line/busy/done/ready value per cycle; pinned literal
// expectations tie the model to hand-worked frames; a loopback receiver checks
// the CLKS_PER_BIT=1 instance byte by byte.
module tb_uart_tx;

    localparam int NI = 5;
    // Per-instance parameters: 0 plain, 1 even, 2 odd, 3 two stop bits, 4 fast loopback.
    localparam int CPB [NI] = '{4, 4, 4, 4, 1};
    localparam int PAR [NI] = '{0, 1, 2, 0, 0};
    localparam int STP [NI] = '{1, 1, 1, 2, 1};

    localparam int M_RST = 0, M_A5 = 1, M_07 = 2, M_B2B = 3, M_GATE = 4;
    localparam int M_DIS = 5, M_EN = 6, M_ABORT = 7, M_POST = 8;
    localparam int SIG_LINE = 0, SIG_BUSY = 1, SIG_DONE = 2, SIG_RDY = 3;

    logic       clock = 1'b0;
    logic       reset, enable, start, lb_start;
    logic [7:0] data, lb_data;
    logic [NI-1:0] so_w, busy_w, done_w, rdy_w;

    always #5 clock = ~clock;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_plain (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .data(data),
        .ready(rdy_w[0]), .busy(busy_w[0]), .serial_out(so_w[0]), .done(done_w[0]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) u_even (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .data(data),
        .ready(rdy_w[1]), .busy(busy_w[1]), .serial_out(so_w[1]), .done(done_w[1]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_odd (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .data(data),
        .ready(rdy_w[2]), .busy(busy_w[2]), .serial_out(so_w[2]), .done(done_w[2]));
    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_stop2 (
        .clock(clock), .reset(reset), .enable(enable), .start(start), .data(data),
        .ready(rdy_w[3]), .busy(busy_w[3]), .serial_out(so_w[3]), .done(done_w[3]));
    uart_tx #(.CLKS_PER_BIT(1), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_fast (
        .clock(clock), .reset(reset), .enable(enable), .start(lb_start), .data(lb_data),
        .ready(rdy_w[4]), .busy(busy_w[4]), .serial_out(so_w[4]), .done(done_w[4]));

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;

    typedef struct {
        int   id;
        int   rel;
        int   inst;
        int   sig;
        logic val;
    } pin_t;
    pin_t pins[$];
    int   mark [9];

    logic       lb_sent [256];
    logic [7:0] lb_bytes [256];
    int         lb_timeouts;
    logic       final_req;
    logic       final_done = 1'b0;

    // Model state: upcoming line values per instance, and the pending done pulse.
    logic        mq [NI][$];
    logic [NI-1:0] done_m = '0;

    int         rx_state = 0;
    int         rx_bit = 0;
    int         rx_idx = 0;
    logic [7:0] rx_byte = '0;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic add_pin(input int id, input int rel, input int inst, input int sig, input logic val);
        pin_t p;
        p.id = id; p.rel = rel; p.inst = inst; p.sig = sig; p.val = val;
        pins.push_back(p);
    endtask

    task automatic chk_bit(input string nm, input int i, input logic got, input logic exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s u%0d @cyc %0d: got %b, expected %b", nm, i, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string nm, input int got, input int exp);
        vectors++;
        if (got != exp) begin
            miscompares++;
            $display("FAIL %s @cyc %0d: got %0d, expected %0d", nm, cyc, got, exp);
        end
    endtask

    function automatic logic pin_sig(input int sig, input int i);
        case (sig)
            SIG_LINE: return so_w[i];
            SIG_BUSY: return busy_w[i];
            SIG_DONE: return done_w[i];
            default:  return rdy_w[i];
        endcase
    endfunction

    // Whole frame as a list of per-cycle line levels.
    function automatic void push_frame(input int i, input logic [7:0] d);
        int   ones;
        logic par;
        ones = 0;
        for (int b = 0; b < 8; b++) ones += int'(d[b]);
        par = ((ones % 2) == 1);
        if (PAR[i] == 2) par = !par;
        repeat (CPB[i]) mq[i].push_back(1'b0);
        for (int b = 0; b < 8; b++) repeat (CPB[i]) mq[i].push_back(d[b]);
        if (PAR[i] != 0) repeat (CPB[i]) mq[i].push_back(par);
        repeat (STP[i] * CPB[i]) mq[i].push_back(1'b1);
    endfunction

    // Single checker: model compare, pinned literals, loopback receiver, final counts.
    always @(negedge clock) begin
        if (cyc >= 1) begin
            for (int i = 0; i < NI; i++) begin
                logic       empty;
                logic       st_i;
                logic [7:0] d_i;
                empty = (mq[i].size() == 0);
                chk_bit("line", i, so_w[i], empty ? 1'b1 : mq[i][0]);
                chk_bit("busy", i, busy_w[i], !empty);
                chk_bit("done", i, done_w[i], done_m[i]);
                chk_bit("ready", i, rdy_w[i], empty && enable);
                st_i = (i == 4) ? lb_start : start;
                d_i  = (i == 4) ? lb_data : data;
                if (reset) begin
                    mq[i].delete();
                    done_m[i] = 1'b0;
                end else if (!empty) begin
                    void'(mq[i].pop_front());
                    done_m[i] = (mq[i].size() == 0);
                end else begin
                    done_m[i] = 1'b0;
                    if (st_i && enable) push_frame(i, d_i);
                end
            end

            foreach (pins[k]) begin
                if (cyc - mark[pins[k].id] == pins[k].rel) begin
                    chk_bit($sformatf("pin%0d.r%0d.s%0d", pins[k].id, pins[k].rel, pins[k].sig),
                            pins[k].inst, pin_sig(pins[k].sig, pins[k].inst), pins[k].val);
                end
            end

            case (rx_state)
                0: begin
                    if (so_w[4] == 1'b0) begin
                        rx_state = 1;
                        rx_bit   = 0;
                    end
                end
                1: begin
                    rx_byte[rx_bit] = so_w[4];
                    rx_bit++;
                    if (rx_bit == 8) rx_state = 2;
                end
                default: begin
                    chk_bit("lb_stop", 4, so_w[4], 1'b1);
                    if (rx_idx < 256) begin
                        chk_int($sformatf("lb_byte%0d", rx_idx), int'(rx_byte),
                                lb_sent[rx_idx] ? int'(lb_bytes[rx_idx]) : -1);
                        rx_idx++;
                    end
                    rx_state = 0;
                end
            endcase

            if (final_req && !final_done) begin
                chk_int("lb_count", rx_idx, 256);
                chk_int("lb_timeouts", lb_timeouts, 0);
                final_done = 1'b1;
            end
        end
    end

    task automatic build_pins();
        int a5 [8];
        a5 = '{1, 0, 1, 0, 0, 1, 0, 1};
        // Reset state.
        for (int i = 0; i < NI; i++) add_pin(M_RST, 1, i, SIG_LINE, 1'b1);
        add_pin(M_RST, 1, 0, SIG_BUSY, 1'b0);
        add_pin(M_RST, 1, 0, SIG_DONE, 1'b0);
        add_pin(M_RST, 3, 0, SIG_RDY, 1'b1);
        // 0xA5 basic frame, cycle by cycle on the plain instance.
        for (int k = 1; k <= 41; k++) begin
            add_pin(M_A5, k, 0, SIG_LINE, (k <= 4) ? 1'b0 : (k <= 36) ? 1'(a5[(k - 5) / 4]) : 1'b1);
            add_pin(M_A5, k, 0, SIG_BUSY, k <= 40);
            add_pin(M_A5, k, 0, SIG_DONE, k == 41);
        end
        add_pin(M_A5, 37, 1, SIG_LINE, 1'b0);
        add_pin(M_A5, 44, 1, SIG_BUSY, 1'b1);
        add_pin(M_A5, 45, 1, SIG_DONE, 1'b1);
        add_pin(M_A5, 37, 2, SIG_LINE, 1'b1);
        add_pin(M_A5, 45, 2, SIG_DONE, 1'b1);
        add_pin(M_A5, 41, 3, SIG_DONE, 1'b0);
        add_pin(M_A5, 44, 3, SIG_LINE, 1'b1);
        add_pin(M_A5, 45, 3, SIG_DONE, 1'b1);
        // 0x07 parity.
        add_pin(M_07, 37, 1, SIG_LINE, 1'b1);
        add_pin(M_07, 37, 2, SIG_LINE, 1'b0);
        add_pin(M_07, 44, 1, SIG_BUSY, 1'b1);
        add_pin(M_07, 45, 1, SIG_DONE, 1'b1);
        add_pin(M_07, 45, 2, SIG_DONE, 1'b1);
        add_pin(M_07, 45, 2, SIG_BUSY, 1'b0);
        // Back-to-back 0x3C then 0xC3 with two stop bits.
        add_pin(M_B2B, 36, 3, SIG_LINE, 1'b0);
        add_pin(M_B2B, 37, 3, SIG_LINE, 1'b1);
        add_pin(M_B2B, 44, 3, SIG_LINE, 1'b1);
        add_pin(M_B2B, 44, 3, SIG_BUSY, 1'b1);
        add_pin(M_B2B, 45, 3, SIG_DONE, 1'b1);
        add_pin(M_B2B, 45, 3, SIG_LINE, 1'b1);
        add_pin(M_B2B, 46, 3, SIG_LINE, 1'b0);
        add_pin(M_B2B, 46, 3, SIG_BUSY, 1'b1);
        add_pin(M_B2B, 46, 3, SIG_DONE, 1'b0);
        add_pin(M_B2B, 49, 3, SIG_LINE, 1'b0);
        add_pin(M_B2B, 50, 3, SIG_LINE, 1'b1);
        add_pin(M_B2B, 41, 0, SIG_DONE, 1'b1);
        add_pin(M_B2B, 42, 0, SIG_LINE, 1'b0);
        add_pin(M_B2B, 46, 0, SIG_LINE, 1'b1);
        // 0x55 with a start pulse while busy.
        add_pin(M_GATE, 5, 0, SIG_LINE, 1'b1);
        add_pin(M_GATE, 9, 0, SIG_LINE, 1'b0);
        add_pin(M_GATE, 11, 0, SIG_RDY, 1'b0);
        add_pin(M_GATE, 12, 0, SIG_LINE, 1'b0);
        add_pin(M_GATE, 13, 0, SIG_LINE, 1'b1);
        add_pin(M_GATE, 41, 0, SIG_DONE, 1'b1);
        add_pin(M_GATE, 42, 0, SIG_DONE, 1'b0);
        add_pin(M_GATE, 42, 0, SIG_BUSY, 1'b0);
        add_pin(M_GATE, 42, 0, SIG_LINE, 1'b1);
        add_pin(M_GATE, 45, 3, SIG_DONE, 1'b1);
        add_pin(M_GATE, 46, 3, SIG_BUSY, 1'b0);
        // start with enable low.
        for (int k = 1; k <= 5; k++) begin
            add_pin(M_DIS, k, 0, SIG_LINE, 1'b1);
            add_pin(M_DIS, k, 0, SIG_BUSY, 1'b0);
        end
        add_pin(M_DIS, 1, 0, SIG_RDY, 1'b0);
        add_pin(M_DIS, 5, 3, SIG_BUSY, 1'b0);
        // 0x81 with enable dropped mid-frame.
        add_pin(M_EN, 5, 0, SIG_LINE, 1'b1);
        add_pin(M_EN, 9, 0, SIG_LINE, 1'b0);
        add_pin(M_EN, 20, 0, SIG_RDY, 1'b0);
        add_pin(M_EN, 33, 0, SIG_LINE, 1'b1);
        add_pin(M_EN, 40, 0, SIG_BUSY, 1'b1);
        add_pin(M_EN, 41, 0, SIG_DONE, 1'b1);
        add_pin(M_EN, 41, 0, SIG_BUSY, 1'b0);
        add_pin(M_EN, 41, 0, SIG_RDY, 1'b0);
        add_pin(M_EN, 45, 3, SIG_DONE, 1'b1);
        // 0x07 aborted by reset during data bit 3.
        add_pin(M_ABORT, 13, 0, SIG_LINE, 1'b1);
        add_pin(M_ABORT, 17, 0, SIG_LINE, 1'b0);
        add_pin(M_ABORT, 17, 0, SIG_BUSY, 1'b1);
        add_pin(M_ABORT, 19, 0, SIG_LINE, 1'b1);
        add_pin(M_ABORT, 19, 0, SIG_BUSY, 1'b0);
        add_pin(M_ABORT, 19, 0, SIG_DONE, 1'b0);
        add_pin(M_ABORT, 19, 3, SIG_BUSY, 1'b0);
        add_pin(M_ABORT, 41, 0, SIG_DONE, 1'b0);
        add_pin(M_ABORT, 45, 3, SIG_DONE, 1'b0);
        // 0x5A accepted normally after the abort.
        add_pin(M_POST, 1, 0, SIG_LINE, 1'b0);
        add_pin(M_POST, 5, 0, SIG_LINE, 1'b0);
        add_pin(M_POST, 9, 0, SIG_LINE, 1'b1);
        add_pin(M_POST, 41, 0, SIG_DONE, 1'b1);
        add_pin(M_POST, 45, 3, SIG_DONE, 1'b1);
    endtask

    task automatic send(input logic [7:0] d, input int id);
        data  = d;
        start = 1'b1;
        mark[id] = cyc;
        step();
        start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; enable = 1'b1; start = 1'b0; data = '0;
        lb_start = 1'b0; lb_data = '0; lb_timeouts = 0; final_req = 1'b0;
        for (int k = 0; k < 9; k++) mark[k] = -1000000;
        for (int k = 0; k < 256; k++) begin
            lb_sent[k]  = 1'b0;
            lb_bytes[k] = '0;
        end
        mark[M_RST] = 0;
        build_pins();

        repeat (3) step();
        reset = 1'b0;
        repeat (2) step();

        send(8'hA5, M_A5);
        repeat (50) step();
        send(8'h07, M_07);
        repeat (50) step();

        data = 8'h3C; start = 1'b1; mark[M_B2B] = cyc;
        step();
        data = 8'hC3;
        repeat (45) step();
        start = 1'b0;
        repeat (100) step();

        send(8'h55, M_GATE);
        repeat (9) step();
        data = 8'hFF; start = 1'b1;
        step();
        start = 1'b0;
        repeat (45) step();

        enable = 1'b0; data = 8'h00; start = 1'b1; mark[M_DIS] = cyc;
        repeat (5) step();
        start = 1'b0; enable = 1'b1;
        step();

        send(8'h81, M_EN);
        repeat (2) step();
        enable = 1'b0;
        repeat (50) step();
        enable = 1'b1;
        step();

        send(8'h07, M_ABORT);
        repeat (17) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        repeat (40) step();

        send(8'h5A, M_POST);
        repeat (50) step();

        lb_start = 1'b1;
        for (int n = 0; n < 256; n++) begin
            logic [7:0] b;
            bit         got;
            b = 8'($urandom_range(0, 255));
            lb_data = b;
            got = 1'b0;
            for (int t = 0; t < 40 && !got; t++) begin
                if (rdy_w[4]) begin
                    lb_bytes[n] = b;
                    lb_sent[n]  = 1'b1;
                    got = 1'b1;
                end
                step();
            end
            if (!got) lb_timeouts++;
        end
        lb_start = 1'b0;
        repeat (20) step();

        final_req = 1'b1;
        repeat (3) step();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
